// File: rtl/micro_sequencer_if.sv
// Bus between the micro_sequencer and the MIR/control-store + datapath side.
//   MIR_WORD  microword now executing          IR       instruction register
//   PSR_N/Z/V/C condition flags               MEM_ACK  memory completion
//   ADDRESS   next control-store address       MEM_REQ/MEM_RD/MEM_WR memory request/type
//   STALL     suppress register/PSR writes     TIMEOUT  one-cycle memory-timeout pulse
// slave modport: the sequencer; master modport: the control store / datapath / bench.
interface micro_sequencer_if #(
    parameter int DATAWIDTH_BUS_ADDRESS = 11,
    parameter int DATAWIDTH_BUS_WORD    = 41
);
    logic [DATAWIDTH_BUS_WORD-1:0]    MIR_WORD;
    logic [31:0]                      IR;
    logic                             PSR_N;
    logic                             PSR_Z;
    logic                             PSR_V;
    logic                             PSR_C;
    logic                             MEM_ACK;
    logic [DATAWIDTH_BUS_ADDRESS-1:0] ADDRESS;
    logic                             MEM_REQ;
    logic                             MEM_RD;
    logic                             MEM_WR;
    logic                             STALL;
    logic                             TIMEOUT;

    modport slave (
        input  MIR_WORD, IR, PSR_N, PSR_Z, PSR_V, PSR_C, MEM_ACK,
        output ADDRESS, MEM_REQ, MEM_RD, MEM_WR, STALL, TIMEOUT
    );

    modport master (
        output MIR_WORD, IR, PSR_N, PSR_Z, PSR_V, PSR_C, MEM_ACK,
        input  ADDRESS, MEM_REQ, MEM_RD, MEM_WR, STALL, TIMEOUT
    );
endinterface

// File: rtl/micro_sequencer.sv
// Control-store address sequencer for the microprogrammed ARC datapath.
// Picks the next control-store address from the MIR word, PSR flags and IR,
// holds the microprogram while a memory access is pending, and diverts to
// TRAP_ADDRESS when memory fails to acknowledge within MAX_WAIT wait cycles.
// Ports:
//   CLK           single clock, posedge
//   RESET_InHigh  synchronous active-high reset
//   bus           micro_sequencer_if.slave (MIR/IR/flags/ACK in, ADDRESS/MEM_*/STALL/TIMEOUT out)
module micro_sequencer #(
    parameter int                  DATAWIDTH_BUS_ADDRESS = 11,
    parameter int                  DATAWIDTH_BUS_WORD    = 41,
    parameter logic [10:0]         TRAP_ADDRESS          = 11'd2047,
    parameter int                  MAX_WAIT              = 15
) (
    input  logic                CLK,
    input  logic                RESET_InHigh,
    micro_sequencer_if.slave    bus
);
    localparam logic [0:0] ST_RUN  = 1'b0;
    localparam logic [0:0] ST_WAIT = 1'b1;
    localparam logic [3:0] MAX_W   = 4'(MAX_WAIT);

    logic [10:0] cur_addr_q, cur_addr_d;
    logic [0:0]  state_q, state_d;
    logic [3:0]  wcnt_q, wcnt_d;

    logic        rd, wr, access;
    logic [2:0]  cond;
    logic [10:0] jump, inc, next_addr;

    assign rd     = bus.MIR_WORD[19];
    assign wr     = bus.MIR_WORD[18];
    assign cond   = bus.MIR_WORD[13:11];
    assign jump   = bus.MIR_WORD[10:0];
    assign access = rd | wr;
    assign inc    = cur_addr_q + 11'd1;   // wraps 2047 -> 0

    // Datapath fields of the microword are not used for sequencing.
    logic unused_fields;
    assign unused_fields = ^{bus.MIR_WORD[40:20], bus.MIR_WORD[17:14],
                             bus.IR[29:25], bus.IR[18:14], bus.IR[12:0]};

    always_comb begin
        next_addr = inc;
        case (cond)
            3'b001:  if (bus.PSR_N) next_addr = jump;
            3'b010:  if (bus.PSR_Z) next_addr = jump;
            3'b011:  if (bus.PSR_V) next_addr = jump;
            3'b100:  if (bus.PSR_C) next_addr = jump;
            3'b101:  if (bus.IR[13]) next_addr = jump;
            3'b110:  next_addr = jump;
            3'b111:  next_addr = {1'b1, bus.IR[31:30], bus.IR[24:19], 2'b00};
            default: next_addr = inc;
        endcase
    end

    always_comb begin
        bus.ADDRESS = next_addr;
        bus.MEM_REQ = access;
        bus.MEM_RD  = rd;
        bus.MEM_WR  = wr & ~rd;           // read wins when both are set
        bus.STALL   = 1'b0;
        bus.TIMEOUT = 1'b0;
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        if (RESET_InHigh) begin
            bus.ADDRESS = '0;
            bus.MEM_REQ = 1'b0;
            bus.MEM_RD  = 1'b0;
            bus.MEM_WR  = 1'b0;
            state_d     = ST_RUN;
            wcnt_d      = '0;
        end else if (state_q == ST_RUN) begin
            if (access && !bus.MEM_ACK) begin
                bus.ADDRESS = cur_addr_q;
                bus.STALL   = 1'b1;
                wcnt_d      = 4'd1;
                state_d     = ST_WAIT;
            end
        end else begin
            // ACK checked first so it beats the timeout on the last wait cycle.
            if (bus.MEM_ACK) begin
                state_d = ST_RUN;
            end else if (wcnt_q == MAX_W) begin
                bus.ADDRESS = TRAP_ADDRESS;
                bus.TIMEOUT = 1'b1;
                bus.STALL   = 1'b1;
                state_d     = ST_RUN;
            end else begin
                bus.ADDRESS = cur_addr_q;
                bus.STALL   = 1'b1;
                wcnt_d      = wcnt_q + 4'd1;
            end
        end
    end

    // CUR_ADDR follows whatever address the MIR loads on this edge.
    assign cur_addr_d = bus.ADDRESS;

    always_ff @(posedge CLK) begin
        if (RESET_InHigh) begin
            cur_addr_q <= '0;
            state_q    <= ST_RUN;
            wcnt_q     <= '0;
        end else begin
            cur_addr_q <= cur_addr_d;
            state_q    <= state_d;
            wcnt_q     <= wcnt_d;
        end
    end
endmodule

// File: tb/tb_micro_sequencer.sv
module tb_micro_sequencer;
    logic CLK = 1'b0;
    logic RESET_InHigh = 1'b1;

    micro_sequencer_if bus ();

    micro_sequencer dut (
        .CLK          (CLK),
        .RESET_InHigh (RESET_InHigh),
        .bus          (bus.slave)
    );

    always #5 CLK = ~CLK;

    // expected {ADDRESS, MEM_REQ, MEM_RD, MEM_WR, STALL, TIMEOUT}
    logic [15:0] exp_q[$];
    string       name_q[$];
    int          total = 0;
    int          bad   = 0;

    localparam logic [4:0] C_NONE   = 5'b00000;
    localparam logic [4:0] C_RD     = 5'b11000;
    localparam logic [4:0] C_RD_ST  = 5'b11010;
    localparam logic [4:0] C_WR     = 5'b10100;
    localparam logic [4:0] C_WR_ST  = 5'b10110;
    localparam logic [4:0] C_TRAP   = 5'b10111;

    localparam logic [31:0] IR_1600 = 32'h8080_0000;
    localparam logic [31:0] IR_1584 = 32'h8060_0000;
    localparam logic [31:0] IR_B13  = 32'h0000_2000;

    function automatic logic [40:0] mw(input logic rd, input logic wr,
                                       input logic [2:0] cond, input logic [10:0] jump);
        return {21'b0, rd, wr, 4'b0, cond, jump};
    endfunction

    // Drive one cycle's inputs and queue the response expected in that cycle.
    task automatic step(input logic [40:0] w, input logic [31:0] ir, input logic [3:0] nzvc,
                        input logic ack, input logic rst, input logic [10:0] ea,
                        input logic [4:0] ectl, input string nm);
        @(posedge CLK);
        #1;
        RESET_InHigh = rst;
        bus.MIR_WORD = w;
        bus.IR       = ir;
        {bus.PSR_N, bus.PSR_Z, bus.PSR_V, bus.PSR_C} = nzvc;
        bus.MEM_ACK  = ack;
        exp_q.push_back({ea, ectl});
        name_q.push_back(nm);
    endtask

    always @(negedge CLK) begin
        if (exp_q.size() > 0) begin
            logic [15:0] e, a;
            string       n;
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = {bus.ADDRESS, bus.MEM_REQ, bus.MEM_RD, bus.MEM_WR, bus.STALL, bus.TIMEOUT};
            total++;
            if (a !== e) begin
                bad++;
                $display("FAIL %s: got addr=%0d req/rd/wr/stall/to=%b, want addr=%0d req/rd/wr/stall/to=%b",
                         n, a[15:5], a[4:0], e[15:5], e[4:0]);
            end
        end
    end

    initial begin
        bus.MIR_WORD = mw(1'b1, 1'b1, 3'b110, 11'd5);
        bus.IR       = '0;
        {bus.PSR_N, bus.PSR_Z, bus.PSR_V, bus.PSR_C} = 4'b0000;
        bus.MEM_ACK  = 1'b0;

        // reset: address 0, all controls low even with an access word in the MIR
        for (int i = 0; i < 3; i++)
            step(mw(1'b1, 1'b1, 3'b110, 11'd5), '0, 4'b0000, 1'b0, 1'b1, 11'd0, C_NONE, "reset");

        // sequencing from word 0
        step(mw(0, 0, 3'b000, 11'd0),   '0,      4'b0000, 0, 0, 11'd1,    C_NONE, "inc_after_reset");
        step(mw(0, 0, 3'b111, 11'd0),   IR_1600, 4'b0000, 0, 0, 11'd1600, C_NONE, "decode_1600");
        step(mw(0, 0, 3'b111, 11'd0),   IR_1584, 4'b0000, 0, 0, 11'd1584, C_NONE, "decode_1584");
        step(mw(0, 0, 3'b010, 11'd12),  '0,      4'b0100, 0, 0, 11'd12,   C_NONE, "z_taken");
        step(mw(0, 0, 3'b110, 11'd8),   '0,      4'b0000, 0, 0, 11'd8,    C_NONE, "jump_8");
        step(mw(0, 0, 3'b010, 11'd12),  '0,      4'b1011, 0, 0, 11'd9,    C_NONE, "z_not_taken");
        step(mw(0, 0, 3'b001, 11'd100), '0,      4'b1000, 0, 0, 11'd100,  C_NONE, "n_taken");
        step(mw(0, 0, 3'b011, 11'd200), '0,      4'b1101, 0, 0, 11'd101,  C_NONE, "v_not_taken");
        step(mw(0, 0, 3'b100, 11'd300), '0,      4'b0001, 0, 0, 11'd300,  C_NONE, "c_taken");
        step(mw(0, 0, 3'b101, 11'd400), IR_B13,  4'b0000, 0, 0, 11'd400,  C_NONE, "ir13_taken");
        step(mw(0, 0, 3'b101, 11'd500), ~IR_B13, 4'b1111, 0, 0, 11'd401,  C_NONE, "ir13_not_taken");
        step(mw(0, 0, 3'b110, 11'd2047),'0,      4'b0000, 0, 0, 11'd2047, C_NONE, "jump_2047");
        step(mw(0, 0, 3'b000, 11'd0),   '0,      4'b0000, 0, 0, 11'd0,    C_NONE, "wrap_to_0");

        // read acknowledged after 3 wait cycles (cur=0)
        step(mw(1, 0, 3'b110, 11'd50), '0, 4'b0000, 0, 0, 11'd0,  C_RD_ST, "rd_wait1");
        step(mw(1, 0, 3'b110, 11'd50), '0, 4'b0000, 0, 0, 11'd0,  C_RD_ST, "rd_wait2");
        step(mw(1, 0, 3'b110, 11'd50), '0, 4'b0000, 0, 0, 11'd0,  C_RD_ST, "rd_wait3");
        step(mw(1, 0, 3'b110, 11'd50), '0, 4'b0000, 1, 0, 11'd50, C_RD,    "rd_ack");

        // flags at the ACK cycle decide the branch (cur=50)
        step(mw(1, 0, 3'b010, 11'd60), '0, 4'b0100, 0, 0, 11'd50, C_RD_ST, "flag_wait");
        step(mw(1, 0, 3'b010, 11'd60), '0, 4'b0000, 1, 0, 11'd51, C_RD,    "flag_at_ack");

        // zero-wait read; ACK ignored without a request
        step(mw(1, 0, 3'b000, 11'd0), '0, 4'b0000, 1, 0, 11'd52, C_RD,   "rd_zero_wait");
        step(mw(0, 0, 3'b000, 11'd0), '0, 4'b0000, 1, 0, 11'd53, C_NONE, "ack_no_req");

        // write never acknowledged -> trap (cur=53)
        step(mw(0, 1, 3'b110, 11'd70), '0, 4'b0000, 0, 0, 11'd53, C_WR_ST, "wr_to_start");
        for (int i = 0; i < 14; i++)
            step(mw(0, 1, 3'b110, 11'd70), '0, 4'b0000, 0, 0, 11'd53, C_WR_ST, "wr_to_wait");
        step(mw(0, 1, 3'b110, 11'd70), '0, 4'b0000, 0, 0, 11'd2047, C_TRAP, "wr_trap");
        step(mw(0, 0, 3'b000, 11'd0),  '0, 4'b0000, 0, 0, 11'd0,    C_NONE, "trap_word_runs");

        // ACK on the timeout cycle wins (cur=0)
        step(mw(0, 1, 3'b110, 11'd80), '0, 4'b0000, 0, 0, 11'd0, C_WR_ST, "late_start");
        for (int i = 0; i < 14; i++)
            step(mw(0, 1, 3'b110, 11'd80), '0, 4'b0000, 0, 0, 11'd0, C_WR_ST, "late_wait");
        step(mw(0, 1, 3'b110, 11'd80), '0, 4'b0000, 1, 0, 11'd80, C_WR, "late_ack_wins");

        // RD+WR: read priority; reset at WCNT=5 aborts the access (cur=80)
        step(mw(1, 1, 3'b000, 11'd0), '0, 4'b0000, 0, 0, 11'd80, C_RD_ST, "rdwr_start");
        for (int i = 0; i < 4; i++)
            step(mw(1, 1, 3'b000, 11'd0), '0, 4'b0000, 0, 0, 11'd80, C_RD_ST, "rdwr_wait");
        step(mw(1, 1, 3'b000, 11'd0), '0, 4'b0000, 0, 1, 11'd0, C_NONE, "reset_in_wait");
        step(mw(0, 0, 3'b000, 11'd0), '0, 4'b0000, 0, 0, 11'd1, C_NONE, "run_after_abort");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(negedge CLK);
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: got %0d pending, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
